// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: function codes, multiply/divide
// unit state encoding and the default datapath width.
package mips_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Multiply/divide step datapath. Works on unsigned magnitudes only; the
// caller handles signs. One shift-add (multiply) or restoring
// shift-subtract (divide) step per enabled cycle on a 2*WIDTH accumulator.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_load,
    input  logic               i_step,
    input  logic               i_is_div,
    input  logic [WIDTH-1:0]   i_mag1,
    input  logic [WIDTH-1:0]   i_mag2,
    output logic [2*WIDTH-1:0] o_product,
    output logic [WIDTH-1:0]   o_quot,
    output logic [WIDTH-1:0]   o_rem
);

    // r_m is the multiplicand for multiply and the divisor for divide.
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_m;
    logic               r_is_div;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_mul_nxt;
    logic [2*WIDTH-1:0] w_div_nxt;

    // Single step of each algorithm; the divide trial borrow decides the quotient bit.
    always_comb begin
        w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
        w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
        w_trial   = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};
        if (w_trial[WIDTH])
            w_div_nxt = {r_acc[2*WIDTH-2:0], 1'b0};
        else
            w_div_nxt = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end

    // Load operands on acceptance, then advance one step per enabled cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc    <= '0;
            r_m      <= '0;
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_is_div <= i_is_div;
            r_m      <= i_is_div ? i_mag2 : i_mag1;
            r_acc    <= {{WIDTH{1'b0}}, (i_is_div ? i_mag1 : i_mag2)};
        end else if (i_step) begin
            r_acc    <= r_is_div ? w_div_nxt : w_mul_nxt;
        end
    end

    assign o_product = r_acc;
    assign o_quot    = r_acc[WIDTH-1:0];
    assign o_rem     = r_acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// FSM, iteration counter, sign handling and HI/LO writes live here;
// the step datapath is in mdu_iter.
//
//   state   | meaning
//   IDLE    | accepts MULT/DIV starts and MTHI/MTLO writes
//   RUN     | WIDTH iteration steps, counter counts down to 0
//   FIX     | apply signs / divide-by-zero override, write HI/LO
module mdu
    import mips_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [5:0]       i_control,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_dz,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_t r_state, w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_dz_out;

    logic               w_is_mul_op, w_is_div_op, w_is_signed;
    logic               w_accept, w_step;
    logic               w_neg1, w_neg2;
    logic [WIDTH-1:0]   w_mag1, w_mag2;
    logic [2*WIDTH-1:0] w_product, w_prod_fix;
    logic [WIDTH-1:0]   w_quot, w_rem;
    logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

    assign w_is_mul_op = (i_control == FN_MULT) || (i_control == FN_MULTU);
    assign w_is_div_op = (i_control == FN_DIV)  || (i_control == FN_DIVU);
    assign w_is_signed = (i_control == FN_MULT) || (i_control == FN_DIV);
    assign w_accept    = (r_state == ST_IDLE) && i_start && (w_is_mul_op || w_is_div_op);
    assign w_step      = (r_state == ST_RUN);

    assign w_neg1 = w_is_signed & i_op1[WIDTH-1];
    assign w_neg2 = w_is_signed & i_op2[WIDTH-1];
    assign w_mag1 = w_neg1 ? -i_op1 : i_op1;
    assign w_mag2 = w_neg2 ? -i_op2 : i_op2;

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_load    (w_accept),
        .i_step    (w_step),
        .i_is_div  (w_is_div_op),
        .i_mag1    (w_mag1),
        .i_mag2    (w_mag2),
        .o_product (w_product),
        .o_quot    (w_quot),
        .o_rem     (w_rem)
    );

    // Next-state decode; RUN leaves when the counter is about to reach 0.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)            w_state_nxt = ST_RUN;
            ST_RUN:  if (r_cnt == CW'(1))     w_state_nxt = ST_FIX;
            ST_FIX:                           w_state_nxt = ST_IDLE;
            default:                          w_state_nxt = ST_IDLE;
        endcase
    end

    // Sign correction and divide-by-zero override; MIN_INT/-1 wraps naturally.
    always_comb begin
        w_prod_fix = r_neg_q ? -w_product : w_product;
        w_fix_hi   = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fix_lo   = w_prod_fix[WIDTH-1:0];
        if (r_is_div) begin
            if (r_dz) begin
                w_fix_lo = '1;
                w_fix_hi = r_op1;
            end else begin
                w_fix_lo = r_neg_q ? -w_quot : w_quot;
                w_fix_hi = r_neg_r ? -w_rem  : w_rem;
            end
        end
    end

    // State register, iteration counter and per-operation flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_op1    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt    <= CW'(WIDTH);
                r_is_div <= w_is_div_op;
                r_neg_q  <= w_neg1 ^ w_neg2;
                r_neg_r  <= w_neg1;
                r_dz     <= w_is_div_op && (i_op2 == '0);
                r_op1    <= i_op1;
            end else if (w_step) begin
                r_cnt    <= r_cnt - CW'(1);
            end
        end
    end

    // HI/LO architectural registers and the one-cycle done/dz pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
            r_dz_out <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_dz_out <= 1'b0;
            if (r_state == ST_FIX) begin
                r_hi     <= w_fix_hi;
                r_lo     <= w_fix_lo;
                r_done   <= 1'b1;
                r_dz_out <= r_dz;
            end else if (r_state == ST_IDLE && i_start) begin
                if (i_control == FN_MTHI) r_hi <= i_op1;
                if (i_control == FN_MTLO) r_lo <= i_op1;
            end
        end
    end

    assign o_busy = (r_state != ST_IDLE);
    assign o_done = r_done;
    assign o_dz   = r_dz_out;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu at WIDTH=32: a table of directed mult/div
// vectors plus hand-written sequences for the multi-cycle corner cases.
module tb_mdu;
    import mips_pkg::*;

    localparam int W = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [5:0]   ctrl;
    logic [W-1:0] op1, op2;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [5:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vec_t;

    vec_t vecs[12];

    mdu #(.WIDTH(W)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_start   (start),
        .i_control (ctrl),
        .i_op1     (op1),
        .i_op2     (op2),
        .o_busy    (busy),
        .o_done    (done),
        .o_dz      (dz),
        .o_hi      (hi),
        .o_lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Start edge falls between this negedge and the next; returns in cycle k+1.
    task automatic issue(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; ctrl = c; op1 = a; op2 = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for o_done; c0 is the current cycle index relative to the start edge.
    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (!done && c < 120) begin
            @(negedge clk);
            c++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no o_done expected o_done within %0d cycles", LAT);
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{FN_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vecs[1]  = '{FN_MULTU, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 1'b0};
        vecs[2]  = '{FN_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{FN_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{FN_DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{FN_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[7]  = '{FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[8]  = '{FN_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{FN_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[10] = '{FN_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0};
        vecs[11] = '{FN_MULT,  32'h00012345, 32'hFFFF0000, 32'hFFFFFFFE, 32'hDCBB0000, 1'b0};

        rst = 1'b1; start = 1'b0; ctrl = '0; op1 = '0; op2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_dz",   64'(dz),   64'd0);
        chk("reset_hi",   64'(hi),   64'd0);
        chk("reset_lo",   64'(lo),   64'd0);
        rst = 1'b0;

        // Table-driven mult/div vectors with latency and pulse-shape checks.
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].c, vecs[i].a, vecs[i].b);
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'd1);
            op1 = 32'hDEADBEEF; op2 = 32'h0BADF00D;
            wait_done(1, n);
            chk($sformatf("v%0d_latency", i), 64'(n), 64'(LAT));
            chk($sformatf("v%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
            chk($sformatf("v%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
            chk($sformatf("v%0d_dz", i), 64'(dz), 64'(vecs[i].dz));
            chk($sformatf("v%0d_busy_at_done", i), 64'(busy), 64'd0);
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
            chk($sformatf("v%0d_dz_clear", i), 64'(dz), 64'd0);
        end

        // MTHI / MTLO writes, and a no-op funct code.
        issue(FN_MTHI, 32'h1234, 32'h0);
        chk("mthi_hi",   64'(hi),   64'h1234);
        chk("mthi_busy", 64'(busy), 64'd0);
        chk("mthi_done", 64'(done), 64'd0);
        issue(FN_MTLO, 32'h5678, 32'h0);
        chk("mtlo_lo",   64'(lo),   64'h5678);
        chk("mtlo_hi",   64'(hi),   64'h1234);
        issue(FN_MFHI, 32'hAAAA, 32'h0);
        chk("mfhi_noop_hi",   64'(hi),   64'h1234);
        chk("mfhi_noop_busy", 64'(busy), 64'd0);

        // Start at cycle k+5 of a running DIVU is ignored.
        issue(FN_DIVU, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1; ctrl = FN_MULT; op1 = 32'd9; op2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        wait_done(6, n);
        chk("ign_latency", 64'(n),  64'(LAT));
        chk("ign_lo",      64'(lo), 64'd14);
        chk("ign_hi",      64'(hi), 64'd2);
        repeat (LAT + 2) @(negedge clk);
        chk("ign_no_second", 64'(busy), 64'd0);
        chk("ign_lo_kept",   64'(lo),   64'd14);

        // Back-to-back: new start during the o_done cycle.
        issue(FN_MULT, 32'd5, 32'd6);
        wait_done(1, n);
        chk("b2b_first_lo", 64'(lo), 64'd30);
        chk("b2b_first_hi", 64'(hi), 64'd0);
        start = 1'b1; ctrl = FN_MULT; op1 = 32'hFFFFFFFE; op2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy_rise", 64'(busy), 64'd1);
        wait_done(1, n);
        chk("b2b_second_latency", 64'(n),  64'(LAT));
        chk("b2b_second_hi",      64'(hi), 64'hFFFFFFFF);
        chk("b2b_second_lo",      64'(lo), 64'hFFFFFFFA);

        // Reset at cycle k+10 of a DIVU discards the operation.
        issue(FN_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_hi",   64'(hi),   64'd0);
        chk("rst_mid_lo",   64'(lo),   64'd0);
        n = 0;
        for (int i = 0; i < LAT + 6; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("rst_mid_no_done", 64'(n), 64'd0);

        // Reset wins over a simultaneous start.
        issue(FN_MTHI, 32'h77, 32'h0);
        @(negedge clk);
        rst = 1'b1; start = 1'b1; ctrl = FN_MULT; op1 = 32'd3; op2 = 32'd4;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_prio_busy", 64'(busy), 64'd0);
        chk("rst_prio_hi",   64'(hi),   64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the MIPS core. It executes MULT, MULTU, DIV and DIVU over a parametrised operand width and holds the results in architectural HI/LO registers. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO. It sits beside the single-cycle ALU in the execute stage, and the core stalls on `o_busy`.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; an even integer ≥ 4.
- `i_clk`  in  1: clock; all state changes on the rising edge.
- `i_rst`  in  1: reset, synchronous, active-high.
- `i_start`  in  1: request; sampled only while idle.
- `i_control`  in  6: function code (MIPS funct field).
- `i_op1`  in  WIDTH: rs operand; the multiplicand or dividend.
- `i_op2`  in  WIDTH: rt operand; the multiplier or divisor.
- `o_busy`  out  1: operation in flight; start requests are ignored while it is high.
- `o_done`  out  1: one-cycle pulse when HI/LO hold a new mult/div result.
- `o_dz`  out  1: divide-by-zero flag, valid only with `o_done`.
- `o_hi`  out  WIDTH: HI register, direct register output.
- `o_lo`  out  WIDTH: LO register, direct register output.

## Operation
- Function codes:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - MTHI 010001, MTLO 010011.
  - MFHI 010000 and MFLO 010010 need no action: the core reads `o_hi`/`o_lo` directly.
- States are IDLE, RUN and FIX.
- IDLE, `i_start`=1:
  - MULT/MULTU/DIV/DIVU: latch the operand magnitudes (absolute value for signed ops), the result signs and a bit counter = WIDTH. Go to RUN.
  - MTHI: HI ← `i_op1`. MTLO: LO ← `i_op1`. Stay in IDLE; `o_done` does not pulse.
  - Any other code: no state change.
- RUN (multiply): one shift-add step per cycle on a 2·WIDTH accumulator.
- RUN (divide): one restoring shift-subtract step per cycle.
- RUN: the counter decrements each cycle; on reaching 0, go to FIX.
- FIX: apply the sign fixes, write HI/LO, go to IDLE and set `o_done`.
  - Product sign = sign(op1) XOR sign(op2).
  - Quotient sign = sign(op1) XOR sign(op2). Remainder sign follows the dividend.
- Multiply results: HI = product[2W-1:W], LO = product[W-1:0]. Arithmetic is modulo 2^(2W).
- Divide results: LO = quotient, HI = remainder.
- Divisor = 0 (DIV or DIVU): LO = all ones, HI = raw `i_op1`, `o_dz`=1. The unit still takes full latency.
- DIV of MIN_INT by −1: LO = MIN_INT, HI = 0, `o_dz`=0. No trap.
- No other overflow signalling.

## Timing
- Reset values: `o_busy`=0, `o_done`=0, `o_dz`=0, `o_hi`=0, `o_lo`=0; state IDLE; counter 0.
- Start accepted at edge k:
  - `o_busy`=1 during cycles k+1 … k+WIDTH+1 (RUN is WIDTH cycles, then FIX is 1 cycle).
  - `o_done`=1 and new `o_hi`/`o_lo` are visible in cycle k+WIDTH+2, with `o_busy`=0.
  - Latency is WIDTH+2 cycles from start to done (34 cycles for WIDTH=32).
- MTHI/MTLO: the value appears on `o_hi`/`o_lo` in the cycle after the start edge. `o_busy` stays 0.
- `i_start` while `o_busy`=1 is dropped silently. Operands are captured only at acceptance, so input changes mid-operation have no effect.
- `i_start` in the `o_done` cycle is accepted, because the unit is IDLE. `o_busy` rises in the next cycle.
- `o_dz` is cleared whenever `o_done`=0.
- `i_rst` mid-operation: at the next edge, return to IDLE with all outputs at reset values. The partial result is discarded.
- `i_rst` has priority over `i_start` in the same cycle.

## Structure
- Shared package `mips_pkg` holds:
  - the funct-code localparams, shared with the ALU;
  - the state encoding (IDLE/RUN/FIX);
  - the `WIDTH` default.
- Sub-module `mdu_iter` holds the accumulator and step datapath:
  - inputs: magnitudes, op select (mul/div), step enable;
  - outputs: raw 2·WIDTH product, or quotient/remainder.
- `mdu` holds the FSM, the counter, sign handling and the HI/LO registers.

## Test plan
- MULT, op1=0xFFFFFFFE, op2=3 → after 34 cycles `o_done`=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV, op1=0xFFFFFFF9 (−7), op2=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, `o_dz`=0. DIVU 100/7 → LO=14, HI=2.
- Edge cases:
  - DIVU 7/0 → LO=0xFFFFFFFF, HI=7, `o_dz`=1 for one cycle.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x1234 → `o_hi`=0x1234 next cycle with `o_busy`=0. A second start (MULT) at cycle k+5 of a running DIV is ignored; the DIV result is unaffected.
- Back-to-back: MULT 5×6, with a new start during its `o_done` cycle → both complete. LO=30 first, then the second result 34 cycles later.
- `i_rst` at cycle 10 of a DIVU → next cycle `o_busy`=0, HI=LO=0, and no `o_done` pulse follows.
